// File: rtl/ltc_timestamp_reader_pkg.sv
// Shared types for the LTC timestamp read path: 64-bit timestamp, assembler
// states, and the 32-bit word width the FIFO delivers.
package ltc_pkg;

  typedef logic [63:0] ts_t;

  typedef enum logic {
    ASM_LO,
    ASM_HI
  } asm_state_e;

  localparam int TS_WORDS = 2;
  localparam int WORD_W   = $bits(ts_t) / TS_WORDS;

endpackage

// File: rtl/ltc_timestamp_reader_if.sv
// AXI-Stream channel carrying assembled 64-bit timestamps toward the DMA path.
interface ltc_timestamp_reader_if;
  import ltc_pkg::*;

  ts_t  tdata;
  logic tvalid;
  logic tready;
  logic tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ltc_timestamp_reader_assembler.sv
// Pairs consecutive FIFO words into one timestamp; the low word always
// arrives first, so a strobe fires on every second accepted word.
module ltc_ts_assembler
  import ltc_pkg::*;
(
  input  logic              clk,
  input  logic              aresetn_local,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word,
  output ts_t               ts,
  output logic              ts_strobe
);

  asm_state_e        state;
  asm_state_e        state_next;
  logic [WORD_W-1:0] lo_word;

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      state <= ASM_LO;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      lo_word <= '0;
    end else if (word_valid && state == ASM_LO) begin
      lo_word <= word;
    end
  end

  // The high word is combined straight off the FIFO data bus in its return cycle.
  always_comb begin
    state_next = state;
    ts_strobe  = 1'b0;
    ts         = {word, lo_word};
    case (state)
      ASM_LO: begin
        if (word_valid) begin
          state_next = ASM_HI;
        end
      end
      ASM_HI: begin
        if (word_valid) begin
          ts_strobe  = 1'b1;
          state_next = ASM_LO;
        end
      end
      default: begin
        state_next = ASM_LO;
      end
    endcase
  end

endmodule

// File: rtl/ltc_timestamp_reader.sv
// Drains the LTC timestamp FIFO, assembles 64-bit timestamps and emits them as
// count-based AXI-Stream packets, flushing a lone held beat after an idle timeout.
module ltc_timestamp_reader
  import ltc_pkg::*;
#(
  parameter int PKT_LEN_W = 16,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  aresetn_local,
  input  logic                  enable,
  input  logic [PKT_LEN_W-1:0]  pkt_len,
  input  logic [PKT_LEN_W-1:0]  timeout,
  input  logic                  fifo_not_empty,
  input  logic [WORD_W-1:0]     fifo_dout,
  output logic                  fifo_rden,
  ltc_timestamp_reader_if.master m_axis,
  output logic [CNT_W-1:0]      ts_count,
  output logic                  err_nonmono
);

  logic                 rd_pending;
  ts_t                  ts;
  logic                 ts_strobe;

  logic                 hold_valid;
  ts_t                  hold_data;
  logic                 out_valid;
  ts_t                  out_data;
  logic                 out_last;

  logic [PKT_LEN_W-1:0] pkt_cnt;
  logic [PKT_LEN_W-1:0] idle_cnt;
  logic [PKT_LEN_W-1:0] last_idx;

  logic                 prev_valid;
  ts_t                  prev_ts;

  logic                 strobe_move;
  logic                 flush;
  logic                 load_out;
  logic                 load_last;
  logic                 handshake;

  // Stalling reads while both slots are full guarantees the output slot is
  // free whenever a new timestamp must push the held one forward.
  assign fifo_rden = fifo_not_empty && enable && !rd_pending && !(hold_valid && out_valid);

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= fifo_rden;
    end
  end

  ltc_ts_assembler u_assembler (
    .clk           (clk),
    .aresetn_local (aresetn_local),
    .word_valid    (rd_pending),
    .word          (fifo_dout),
    .ts            (ts),
    .ts_strobe     (ts_strobe)
  );

  assign last_idx    = (pkt_len == '0) ? '0 : pkt_len - 1'b1;
  assign strobe_move = ts_strobe && hold_valid;
  assign flush       = hold_valid && !ts_strobe && (idle_cnt == timeout) && !out_valid;
  assign load_out    = strobe_move || flush;
  assign load_last   = flush || (pkt_cnt == last_idx);
  assign handshake   = out_valid && m_axis.tready;

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (ts_strobe) begin
      hold_valid <= 1'b1;
      hold_data  <= ts;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end
  end

  // A slot freed by a handshake only reloads on the following cycle.
  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= hold_data;
      out_last  <= load_last;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      pkt_cnt <= '0;
    end else if (load_out) begin
      pkt_cnt <= load_last ? '0 : pkt_cnt + 1'b1;
    end
  end

  // Saturates at timeout so a flush blocked by a busy output fires once it frees.
  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      idle_cnt <= '0;
    end else if (ts_strobe) begin
      idle_cnt <= '0;
    end else if (hold_valid) begin
      if (idle_cnt == timeout) begin
        if (!out_valid) begin
          idle_cnt <= '0;
        end
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn_local) begin
    if (!aresetn_local) begin
      prev_valid  <= 1'b0;
      prev_ts     <= '0;
      err_nonmono <= 1'b0;
      ts_count    <= '0;
    end else if (ts_strobe) begin
      prev_valid <= 1'b1;
      prev_ts    <= ts;
      ts_count   <= ts_count + 1'b1;
      if (prev_valid && ts <= prev_ts) begin
        err_nonmono <= 1'b1;
      end
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;

endmodule

// File: tb/tb_ltc_timestamp_reader.sv
// Self-checking bench: a queue-based model of the timestamp stream is compared
// against the DUT every cycle, with directed scenarios plus randomized traffic.
module tb_ltc_timestamp_reader;
  import ltc_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn_local;
  logic        enable;
  logic [15:0] pkt_len;
  logic [15:0] timeout;
  logic        fifo_not_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rden;
  logic [31:0] ts_count;
  logic        err_nonmono;

  ltc_timestamp_reader_if axis_if ();

  ltc_timestamp_reader #(
    .PKT_LEN_W (16),
    .CNT_W     (32)
  ) dut (
    .clk            (clk),
    .aresetn_local  (aresetn_local),
    .enable         (enable),
    .pkt_len        (pkt_len),
    .timeout        (timeout),
    .fifo_not_empty (fifo_not_empty),
    .fifo_dout      (fifo_dout),
    .fifo_rden      (fifo_rden),
    .m_axis         (axis_if),
    .ts_count       (ts_count),
    .err_nonmono    (err_nonmono)
  );

  always #5 clk = ~clk;

  // A model entry is a timestamp still owed to the stream; it is committed once
  // its tlast is decided, and only a committed head is visible on the bus.
  typedef struct {
    ts_t ts;
    bit  committed;
    bit  last;
  } ent_t;

  typedef struct {
    ts_t ts;
    bit  last;
  } beat_t;

  ent_t        pipe[$];
  beat_t       obs[$];
  logic [31:0] fifo_q[$];
  ts_t         sent[$];

  int          checks = 0;
  int          errors = 0;
  int          en_pct;
  int          rdy_pct;
  int          rden_seen;

  bit          m_pending;
  bit          m_half;
  logic [31:0] m_lo;
  logic [31:0] m_word;
  int          m_idle;
  int          m_pos;
  logic [31:0] m_count;
  bit          m_have_prev;
  bit          m_err;
  ts_t         m_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_rden();
    return fifo_not_empty && enable && !m_pending && (pipe.size() < 2);
  endfunction

  function automatic bit head_visible();
    if (pipe.size() == 0) return 1'b0;
    return pipe[0].committed;
  endfunction

  task automatic model_clear();
    pipe.delete();
    obs.delete();
    m_pending   = 0;
    m_half      = 0;
    m_lo        = '0;
    m_word      = '0;
    m_idle      = 0;
    m_pos       = 0;
    m_count     = '0;
    m_have_prev = 0;
    m_err       = 0;
    m_prev      = '0;
  endtask

  task automatic checkOutput();
    bit ev;
    ev = head_visible();
    chk("fifo_rden", fifo_rden, exp_rden());
    chk("tvalid", axis_if.tvalid, ev);
    if (ev) begin
      chk("tdata", axis_if.tdata, pipe[0].ts);
      chk("tlast", axis_if.tlast, pipe[0].last);
    end
    chk("ts_count", ts_count, m_count);
    chk("err_nonmono", err_nonmono, m_err);
    if (fifo_rden) rden_seen++;
    if (axis_if.tvalid && axis_if.tready) obs.push_back('{axis_if.tdata, axis_if.tlast});
  endtask

  // Advances the model across the coming rising edge using this cycle's inputs.
  task automatic model_step();
    bit   hs;
    bit   rd;
    bit   strobe;
    ts_t  ts;
    int   eff;
    int   idx;
    ent_t e;
    hs     = head_visible() && axis_if.tready;
    rd     = exp_rden();
    strobe = 0;
    ts     = '0;
    eff    = (pkt_len == 0) ? 1 : int'(pkt_len);
    if (m_pending) begin
      if (!m_half) begin
        m_lo   = m_word;
        m_half = 1;
      end else begin
        ts     = {m_word, m_lo};
        m_half = 0;
        strobe = 1;
      end
    end
    idx = pipe.size() - 1;
    if (strobe) begin
      m_count++;
      if (m_have_prev && ts <= m_prev) m_err = 1;
      m_prev      = ts;
      m_have_prev = 1;
      if (pipe.size() > 0 && !pipe[idx].committed) begin
        e           = pipe[idx];
        e.committed = 1;
        e.last      = (m_pos == eff - 1);
        pipe[idx]   = e;
        m_pos       = e.last ? 0 : m_pos + 1;
      end
      pipe.push_back('{ts, 1'b0, 1'b0});
      m_idle = 0;
    end else if (pipe.size() > 0 && !pipe[idx].committed) begin
      if (m_idle >= int'(timeout) && pipe.size() == 1) begin
        e           = pipe[idx];
        e.committed = 1;
        e.last      = 1;
        pipe[idx]   = e;
        m_pos       = 0;
        m_idle      = 0;
      end else begin
        m_idle++;
      end
    end
    if (hs) void'(pipe.pop_front());
    m_pending = rd;
    if (fifo_rden && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    m_word = fifo_dout;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      enable         = ($urandom_range(99) < en_pct);
      axis_if.tready = ($urandom_range(99) < rdy_pct);
      fifo_not_empty = (fifo_q.size() != 0);
      #1;
      checkOutput();
      model_step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn_local  = 1'b0;
    fifo_q.delete();
    fifo_not_empty = 1'b0;
    fifo_dout      = '0;
    #1;
    chk("rst_tvalid", axis_if.tvalid, 0);
    chk("rst_tlast", axis_if.tlast, 0);
    chk("rst_tdata", axis_if.tdata, 0);
    chk("rst_rden", fifo_rden, 0);
    chk("rst_ts_count", ts_count, 0);
    chk("rst_err", err_nonmono, 0);
    model_clear();
    @(negedge clk);
    aresetn_local = 1'b1;
  endtask

  task automatic push_ts(input ts_t t);
    fifo_q.push_back(t[31:0]);
    fifo_q.push_back(t[63:32]);
  endtask

  task automatic check_beat(input string name, input int idx, input ts_t t, input bit last);
    if (idx < obs.size()) begin
      chk({name, "_data"}, obs[idx].ts, t);
      chk({name, "_last"}, obs[idx].last, last);
    end else begin
      chk({name, "_missing"}, obs.size(), idx + 1);
    end
  endtask

  initial begin
    int   lens[3];
    int   tos[3];
    ts_t  cur;
    aresetn_local  = 1'b0;
    enable         = 1'b0;
    axis_if.tready = 1'b0;
    fifo_not_empty = 1'b0;
    fifo_dout      = '0;
    pkt_len        = 16'd1;
    timeout        = 16'd0;
    en_pct         = 100;
    rdy_pct        = 100;
    lens           = '{0, 3, 5};
    tos            = '{0, 7, 20};
    model_clear();

    // Two timestamps, pkt_len 2: the second closes the packet via idle flush.
    pkt_len = 16'd2;
    timeout = 16'd100;
    do_reset();
    push_ts(64'h10);
    push_ts(64'h20);
    applyStimulus(150);
    chk("t1_beats", obs.size(), 2);
    check_beat("t1_b0", 0, 64'h10, 0);
    check_beat("t1_b1", 1, 64'h20, 1);
    chk("t1_ts_count", ts_count, 2);

    // Third beat of a 3-beat packet waits for the long timeout.
    pkt_len = 16'd3;
    timeout = 16'd1000;
    do_reset();
    push_ts(64'h1);
    push_ts(64'h2);
    push_ts(64'h3);
    applyStimulus(40);
    chk("t2_early_beats", obs.size(), 2);
    check_beat("t2_b0", 0, 64'h1, 0);
    check_beat("t2_b1", 1, 64'h2, 0);
    applyStimulus(900);
    chk("t2_still_held", obs.size(), 2);
    applyStimulus(200);
    check_beat("t2_b2", 2, 64'h3, 1);

    // Back-pressure: only two timestamps may be absorbed while tready is low.
    pkt_len = 16'd4;
    timeout = 16'd1000;
    do_reset();
    for (int i = 1; i <= 4; i++) push_ts(64'(i) << 12);
    rdy_pct = 0;
    applyStimulus(50);
    chk("t3_words_left", fifo_q.size(), 4);
    chk("t3_rden_stalled", fifo_rden, 0);
    rdy_pct = 100;
    applyStimulus(1200);
    chk("t3_beats", obs.size(), 4);
    for (int i = 0; i < 4; i++) check_beat("t3_b", i, 64'(i + 1) << 12, (i == 3));

    // Non-monotonic pair sets the sticky error flag.
    pkt_len = 16'd1;
    timeout = 16'd5;
    do_reset();
    push_ts(64'h100);
    push_ts(64'h0F0);
    applyStimulus(20);
    chk("t4_err_set", err_nonmono, 1);
    applyStimulus(50);
    chk("t4_err_sticky", err_nonmono, 1);

    // Reset with a half-assembled word and a beat stalled on the bus.
    pkt_len = 16'd1;
    timeout = 16'd0;
    do_reset();
    push_ts(64'h33);
    fifo_q.push_back(32'hDEAD);
    rdy_pct = 0;
    applyStimulus(10);
    chk("t5_pre_tvalid", axis_if.tvalid, 1);
    do_reset();
    push_ts(64'h5);
    rdy_pct = 100;
    applyStimulus(20);
    chk("t5_beats", obs.size(), 1);
    check_beat("t5_b0", 0, 64'h5, 1);

    // enable dropped between the low and high reads.
    pkt_len = 16'd1;
    timeout = 16'd2;
    do_reset();
    fifo_q.push_back(32'h11223344);
    applyStimulus(5);
    en_pct    = 0;
    rden_seen = 0;
    fifo_q.push_back(32'h55667788);
    applyStimulus(20);
    chk("t6_no_reads", rden_seen, 0);
    en_pct = 100;
    applyStimulus(30);
    check_beat("t6_b0", 0, 64'h55667788_11223344, 1);

    // Randomized traffic against the model, then a full drain.
    for (int k = 0; k < 3; k++) begin
      pkt_len = 16'(lens[k]);
      timeout = 16'(tos[k]);
      do_reset();
      sent.delete();
      cur = 64'h1_0000_0000;
      for (int i = 0; i < 100; i++) begin
        case ($urandom_range(19))
          0:       cur = cur - 64'($urandom_range(1, 50));
          1:       cur = cur + 64'h1_0000_0000;
          default: cur = cur + 64'($urandom_range(1, 5000));
        endcase
        sent.push_back(cur);
        push_ts(cur);
      end
      en_pct  = 80;
      rdy_pct = 60;
      applyStimulus(2000);
      en_pct  = 100;
      rdy_pct = 100;
      applyStimulus(200);
      chk("rnd_beats", obs.size(), sent.size());
      for (int i = 0; i < sent.size() && i < obs.size(); i++) begin
        chk("rnd_order", obs[i].ts, sent[i]);
      end
      chk("rnd_ts_count", ts_count, 100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltc_timestamp_reader.md
Name: ltc_timestamp_reader

Overview:
Read-side consumer of the LTC timestamp FIFO. It drains 32-bit words from the asynchronous timestamp FIFO's read port and pairs them into 64-bit timestamps. Each timestamp is the capture counter bits [64:1], in units of 2 clk. Timestamps leave on an AXI-Stream master, packetised by count with an idle-timeout flush, for the DMA path. The block sits in the FIFO read-clock domain, between the FIFO and the DMA/stream interconnect.

Parameters:
PKT_LEN_W, 16, width of the pkt_len and timeout inputs
CNT_W, 32, width of the ts_count status counter

Ports:
clk  in  1  FIFO read clock; all logic runs on posedge
aresetn_local  in  1  asynchronous, active-low reset; the same reset that clears the FIFO
enable  in  1  permits FIFO reads (register-bank bit, already synchronised)
pkt_len  in  PKT_LEN_W  beats per packet; 0 is treated as 1
timeout  in  PKT_LEN_W  idle cycles before a held beat is flushed with tlast
fifo_not_empty  in  1  FIFO has at least one 32-bit word
fifo_dout  in  32  FIFO read data, valid 1 cycle after fifo_rden
fifo_rden  out  1  FIFO read enable
m_axis_tdata  out  64  timestamp
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tlast  out  1  last beat of packet
ts_count  out  CNT_W  timestamps assembled since reset; wraps
err_nonmono  out  1  sticky flag: a timestamp was <= its predecessor

Behaviour:
- Reset values: fifo_rden 0, tvalid 0, tlast 0, tdata 0, ts_count 0, err_nonmono 0. Assembler state is LO; hold, output and pending registers are empty; pkt and idle counters are 0.
- Read issue: fifo_rden = fifo_not_empty && enable && !rd_pending && !(hold_valid && out_valid).
  - rd_pending is fifo_rden registered.
  - Maximum rate is 1 word per 2 cycles.
- Word return: data is taken from fifo_dout on the cycle rd_pending = 1.
- Assembler FSM:
  - LO: capture word as bits [31:0] and go to HI.
  - HI: form ts = {word, lo}, raise ts_strobe for one cycle, go to LO.
  - The low word is always first (64->32 width conversion order).
- On ts_strobe:
  - ts_count increments.
  - err_nonmono is set if a previous ts exists and ts <= prev. prev then updates to ts.
  - If hold is empty, ts enters hold. Otherwise hold moves to the output register with tlast = (pkt_cnt == max(pkt_len,1)-1), and ts enters hold.
  - The read gating guarantees the output register is free whenever a move is required.
- pkt_cnt: increments on each beat moved to output; clears to 0 on any tlast beat. The tlast decision uses pkt_cnt before the increment.
- Idle flush:
  - The idle counter clears on ts_strobe and counts while hold_valid and no strobe occurs.
  - When idle == timeout and the output register is free, hold moves to output with tlast = 1 and pkt_cnt clears.
  - timeout = 0 flushes on the cycle after entry.
- Output register: tvalid, tdata and tlast stay stable until tvalid && tready. The register is freed that cycle and may reload on the next cycle.
- enable low: no new reads. An in-flight word is still captured. A half-assembled LO word is retained, and hold and output continue draining and flushing.
- Mid-operation reset: all state clears asynchronously. Partial words and held beats are discarded, and the FIFO clears in step, so word alignment is preserved.
- ts_count wraps modulo 2^CNT_W.

Decomposition:
- Package ltc_pkg:
  - typedef ts_t (logic [63:0])
  - enum asm_state_e {ASM_LO, ASM_HI}
  - localparam TS_WORDS = 2
- Sub-module ltc_ts_assembler: takes a word + valid, returns ts_t + strobe. It contains the FSM and the low-word register.
- Top level: read gating, monotonic check, hold/output registers, packet and idle counters.

Test Plan:
- FIFO holds words 0x00000010, 0x00000000, 0x00000020, 0x00000000; pkt_len 2, tready 1, timeout 100 -> beats 0x10 (tlast 0) then 0x20 (tlast 1, after the 100-cycle flush); ts_count 2.
- Three timestamps, pkt_len 3, timeout 1000 -> beats 1 and 2 appear promptly with tlast 0/0; beat 3 appears only after 1000 idle cycles with tlast 1.
- tready held low for 50 cycles with 8 words queued -> at most 2 timestamps buffered; fifo_rden stays 0 once hold and output are full; no data lost after tready returns; order preserved.
- Timestamps 0x100 then 0x0F0 -> err_nonmono rises after the second strobe and stays set until reset.
- Reset asserted after the LO word only -> tvalid 0 immediately; the post-reset words 0x5, 0x0 yield timestamp 0x5 (no stale pairing).
- enable dropped between LO and HI reads -> fifo_rden stays 0 while low; re-enable gives the correct 64-bit value.
